mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DW, default 32, data width; AW, default 32, address width; LOCK_MAX, default 8, maximum consecutive locked grants to m1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 m0_req / m1_req  input  1 each  access request; m0 is the execute-stage load/store port, m1 is the debug/loader port.
REQ-005 mN_we  input  1  write (1) or read (0).
REQ-006 mN_sel  input  4  byte lanes.
REQ-007 mN_addr  input  AW  byte address.
REQ-008 mN_wdata  input  DW  write data.
REQ-009 m1_lock  input  1  m1 requests back-to-back ownership.
REQ-010 mN_gnt  output  1  access accepted this cycle.
REQ-011 mN_rvalid  output  1  read data valid.
REQ-012 mN_rdata  output  DW  read data.
REQ-013 ram_we  output  1  RAM write enable.
REQ-014 ram_sel  output  4  RAM byte lanes.
REQ-015 ram_addr  output  AW  RAM address.
REQ-016 ram_wdata  output  DW  RAM write data.
REQ-017 ram_rdata  input  DW  RAM read data, valid one cycle after a read address is presented.
REQ-018 stall_req  output  1  pipeline stall request to the control block.

Function
REQ-019 Each granted access SHALL occupy the RAM port for exactly one cycle; gnt is combinational from req and registered state in the same cycle.
REQ-020 When exactly one master requests, it SHALL be granted unless a pending read return or lock (REQ-024) forbids it.
REQ-021 When both masters request, the grant SHALL go to the master not granted most recently (round-robin pointer last_q, reset value m1, so m0 wins first).
REQ-022 ram_we/ram_sel/ram_addr/ram_wdata SHALL mirror the granted master's we/sel/addr/wdata; with no grant: ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0.
REQ-023 A granted read SHALL assert that master's rvalid exactly one cycle later with rdata=ram_rdata; the other master's rvalid stays 0 and its rdata is 0.
REQ-024 Lock FSM states: IDLE, LOCKED. IDLE->LOCKED when m1 is granted with m1_lock=1. In LOCKED, m1 has absolute priority. LOCKED->IDLE when m1_lock=0, m1_req=0, or lock_cnt reaches LOCK_MAX; the cycle after exit, m0 wins any conflict.
REQ-025 lock_cnt SHALL count m1 grants in LOCKED, saturate at LOCK_MAX, and clear on entry to IDLE.
REQ-026 stall_req SHALL be 1 when m0_req=1 and m0_gnt=0, or when an m0 read was granted in the previous cycle and m0_rvalid is being returned this cycle is NOT yet reached (i.e. the grant cycle of an m0 read); otherwise 0.
REQ-027 Writes SHALL produce no rvalid.
REQ-028 A request dropped before grant SHALL leave no state change.
REQ-029 Simultaneous m0 write and m1 read SHALL resolve by REQ-021; the loser sees gnt=0 and must hold its request.

Reset
REQ-030 While rst=1, all outputs SHALL be 0, FSM=IDLE, lock_cnt=0, last_q=m1, and pending read-return flags cleared.
REQ-031 A read granted in the cycle rst asserts SHALL NOT produce rvalid after reset release.

Verification
REQ-032 m0 read addr 0x100, ram_rdata=0xDEADBEEF next cycle -> m0_gnt=1 in cycle 0, ram_we=0; m0_rvalid=1, m0_rdata=0xDEADBEEF in cycle 1; stall_req=1 in cycle 0 only.
REQ-033 Both request for 4 cycles from reset -> grants m0,m1,m0,m1; stall_req=1 in cycles 1 and 3.
REQ-034 m1 writes with m1_lock=1 and m0_req=1 held for 12 cycles, LOCK_MAX=8 -> m1 granted 8 cycles, then m0 granted in cycle 8, stall_req=1 in cycles 0-7.
REQ-035 m0 write sel=0011 addr 0x20 wdata 0x0000ABCD -> ram_we=1, ram_sel=0011, ram_addr=0x20, ram_wdata=0x0000ABCD same cycle; no rvalid afterwards.
REQ-036 rst asserted mid-cycle during an m1 read grant -> all outputs 0 immediately; after release m1_rvalid stays 0 and the next conflict is won by m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port pipelined RAM. m0 is the execute-stage
// load/store port, m1 the debug/loader port, which can lock the RAM for bursts.
module mem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_sel,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_sel,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_we,
  output logic [3:0]    ram_sel,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          stall_req
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] lock_cnt, cnt_nx;
  logic          last_q;   // 1: m1 was granted most recently
  logic          pend0, pend1;
  logic          lock_hold;

  // The lock only holds while m1 keeps asking for it and the burst budget remains;
  // otherwise this cycle already arbitrates as if IDLE.
  assign lock_hold = (state == LOCKED) && m1_req && m1_lock && (lock_cnt != CW'(LOCK_MAX));

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (lock_hold || !last_q) m1_gnt = 1'b1;
        else                      m0_gnt = 1'b1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign ram_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign ram_sel   = ({4{m0_gnt}} & m0_sel) | ({4{m1_gnt}} & m1_sel);
  assign ram_addr  = ({AW{m0_gnt}} & m0_addr) | ({AW{m1_gnt}} & m1_addr);
  assign ram_wdata = ({DW{m0_gnt}} & m0_wdata) | ({DW{m1_gnt}} & m1_wdata);

  assign m0_rvalid = pend0;
  assign m1_rvalid = pend1;
  assign m0_rdata  = pend0 ? ram_rdata : '0;
  assign m1_rdata  = pend1 ? ram_rdata : '0;

  // Stall while m0 waits, and during the grant cycle of an m0 load (data arrives next cycle).
  assign stall_req = (m0_req & ~m0_gnt & ~rst) | (m0_gnt & ~m0_we);

  // The grant that enters LOCKED counts toward the burst budget.
  always_comb begin
    state_nx = state;
    cnt_nx   = lock_cnt;
    case (state)
      IDLE: begin
        if (m1_gnt && m1_lock) begin
          state_nx = LOCKED;
          cnt_nx   = CW'(1);
        end
      end
      LOCKED: begin
        if (lock_hold) begin
          if (m1_gnt && lock_cnt != CW'(LOCK_MAX)) cnt_nx = lock_cnt + CW'(1);
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      last_q   <= 1'b1;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
    end else begin
      state    <= state_nx;
      lock_cnt <= cnt_nx;
      if (m0_gnt || m1_gnt) last_q <= m1_gnt;
      pend0    <= m0_gnt & ~m0_we;
      pend1    <= m1_gnt & ~m1_we;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written lock/reset sequences,
// and random traffic against a rule-level reference model.
module tb_mem_arbiter;
  localparam int DW = 32, AW = 32, LOCK_MAX = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [3:0]    m0_sel, m1_sel;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, ram_rdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we, stall_req;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_wdata;
  logic [3:0]    ram_sel;
  logic [AW-1:0] ram_addr;

  int checks = 0, errors = 0;

  mem_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_first;
    bit          r0, w0;
    logic [3:0]  s0;
    logic [31:0] a0, d0;
    bit          r1, w1, l1;
    logic [31:0] a1, rdat;
    bit          g0, g1, st, rwe;
    logic [3:0]  rsel;
    logic [31:0] raddr, rwd;
    bit          rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_outs(input string tag, input bit g0, g1, st, rwe, input logic [3:0] rsel,
                          input logic [31:0] raddr, rwd, input bit rv0, rv1,
                          input logic [31:0] rd0, rd1);
    chk({tag, " m0_gnt"}, 64'(m0_gnt), 64'(g0));
    chk({tag, " m1_gnt"}, 64'(m1_gnt), 64'(g1));
    chk({tag, " stall_req"}, 64'(stall_req), 64'(st));
    chk({tag, " ram_we"}, 64'(ram_we), 64'(rwe));
    chk({tag, " ram_sel"}, 64'(ram_sel), 64'(rsel));
    chk({tag, " ram_addr"}, 64'(ram_addr), 64'(raddr));
    chk({tag, " ram_wdata"}, 64'(ram_wdata), 64'(rwd));
    chk({tag, " m0_rvalid"}, 64'(m0_rvalid), 64'(rv0));
    chk({tag, " m1_rvalid"}, 64'(m1_rvalid), 64'(rv1));
    chk({tag, " m0_rdata"}, 64'(m0_rdata), 64'(rd0));
    chk({tag, " m1_rdata"}, 64'(m1_rdata), 64'(rd1));
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    ram_rdata = 0;
  endtask

  // Leaves the bench at a negedge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    #1 cmp_outs("reset", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic drive(input bit r0, w0, input logic [3:0] s0, input logic [31:0] a0, d0,
                       input bit r1, w1, l1, input logic [3:0] s1, input logic [31:0] a1, d1,
                       input logic [31:0] rdat);
    m0_req = r0; m0_we = w0; m0_sel = s0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_sel = s1; m1_addr = a1; m1_wdata = d1;
    ram_rdata = rdat;
  endtask

  initial begin
    vec_t vecs[11];
    string tag;
    idle_inputs();

    // rst,r0,w0,s0,a0,d0, r1,w1,l1,a1,rdat, g0,g1,st,rwe,rsel,raddr,rwd, rv0,rv1,rd0,rd1
    vecs[0]  = '{1, 1,0,4'hF,32'h100,0,           0,0,0,0,0,             1,0,1,0,4'hF,32'h100,0,           0,0,0,0};
    vecs[1]  = '{0, 0,0,4'h0,0,0,                 0,0,0,0,32'hDEADBEEF,  0,0,0,0,4'h0,0,0,                 1,0,32'hDEADBEEF,0};
    vecs[2]  = '{1, 1,1,4'hF,32'h40,32'h11111111, 1,1,0,32'h80,0,        1,0,0,1,4'hF,32'h40,32'h11111111, 0,0,0,0};
    vecs[3]  = '{0, 1,1,4'hF,32'h40,32'h11111111, 1,1,0,32'h80,0,        0,1,1,1,4'hF,32'h80,32'hCAFE0000, 0,0,0,0};
    vecs[4]  = '{0, 1,1,4'hF,32'h40,32'h11111111, 1,1,0,32'h80,0,        1,0,0,1,4'hF,32'h40,32'h11111111, 0,0,0,0};
    vecs[5]  = '{0, 1,1,4'hF,32'h40,32'h11111111, 1,1,0,32'h80,0,        0,1,1,1,4'hF,32'h80,32'hCAFE0000, 0,0,0,0};
    vecs[6]  = '{1, 1,1,4'h3,32'h20,32'h0000ABCD, 0,0,0,0,0,             1,0,0,1,4'h3,32'h20,32'h0000ABCD, 0,0,0,0};
    vecs[7]  = '{0, 0,0,4'h0,0,0,                 0,0,0,0,32'hFFFFFFFF,  0,0,0,0,4'h0,0,0,                 0,0,0,0};
    vecs[8]  = '{0, 1,1,4'hF,32'h30,32'h77777777, 1,0,0,32'h90,0,        0,1,1,0,4'hF,32'h90,32'hCAFE0000, 0,0,0,0};
    vecs[9]  = '{0, 1,1,4'hF,32'h30,32'h77777777, 0,0,0,0,32'h12345678,  1,0,0,1,4'hF,32'h30,32'h77777777, 0,1,0,32'h12345678};
    vecs[10] = '{0, 0,0,4'h0,0,0,                 0,0,0,0,32'hABABABAB,  0,0,0,0,4'h0,0,0,                 0,0,0,0};

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      else @(negedge clk);
      drive(vecs[i].r0, vecs[i].w0, vecs[i].s0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].r1 ? 4'hF : 4'h0,
            vecs[i].a1, vecs[i].r1 ? 32'hCAFE0000 : 32'h0, vecs[i].rdat);
      tag = $sformatf("vec%0d", i);
      #1 cmp_outs(tag, vecs[i].g0, vecs[i].g1, vecs[i].st, vecs[i].rwe, vecs[i].rsel,
                  vecs[i].raddr, vecs[i].rwd, vecs[i].rv0, vecs[i].rv1, vecs[i].rd0, vecs[i].rd1);
    end

    // Locked burst: one m0 access first so m1 owns the round-robin turn.
    do_reset();
    drive(1, 1, 4'hF, 32'h8, 32'h1, 0, 0, 0, 4'h0, 0, 0, 0);
    #1 chk("lock pre m0_gnt", 64'(m0_gnt), 64'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1, 1, 4'hF, 32'h8, 32'h1, 1, 1, 1, 4'hF, 32'h100 + 32'(i), 32'(i), 0);
      #1;
      if (i <= 8) begin
        tag = $sformatf("lock c%0d", i);
        chk({tag, " m1_gnt"}, 64'(m1_gnt), 64'(i < 8));
        chk({tag, " m0_gnt"}, 64'(m0_gnt), 64'(i == 8));
        chk({tag, " stall"}, 64'(stall_req), 64'(i < 8));
      end
    end

    // Reset asserted before the edge that would capture an m1 read grant.
    do_reset();
    drive(0, 0, 4'h0, 0, 0, 1, 0, 0, 4'hF, 32'h200, 0, 0);
    #1 chk("rstA m1_gnt", 64'(m1_gnt), 64'd1);
    #2 rst = 1;
    #1 cmp_outs("rstA during", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    drive(0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h5A5A5A5A);
    #1 chk("rstA m1_rvalid", 64'(m1_rvalid), 64'd0);
    chk("rstA m1_rdata", 64'(m1_rdata), 64'd0);
    @(negedge clk);
    drive(1, 1, 4'hF, 32'h4, 32'h9, 1, 1, 0, 4'hF, 32'h8, 32'h9, 0);
    #1 chk("rstA conflict m0_gnt", 64'(m0_gnt), 64'd1);
    chk("rstA conflict m1_gnt", 64'(m1_gnt), 64'd0);

    // Reset asserted just after the edge that captured an m1 read grant.
    @(negedge clk);
    drive(0, 0, 4'h0, 0, 0, 1, 0, 0, 4'hF, 32'h300, 0, 32'h77);
    @(posedge clk);
    #1 rst = 1;
    #1 chk("rstB m1_rvalid", 64'(m1_rvalid), 64'd0);
    @(negedge clk);
    idle_inputs();
    ram_rdata = 32'h66;
    @(negedge clk);
    rst = 0;
    #1 chk("rstB after m1_rvalid", 64'(m1_rvalid), 64'd0);
    @(negedge clk);
    drive(1, 1, 4'hF, 32'h4, 32'h9, 1, 1, 0, 4'hF, 32'h8, 32'h9, 0);
    #1 chk("rstB conflict m0_gnt", 64'(m0_gnt), 64'd1);

    // Random traffic against the rule-level model.
    do_reset();
    begin
      int  last = 1, cnt = 0, win;
      bit  locked = 0, pend0 = 0, pend1 = 0, hold;
      logic [3:0]  esel;
      logic [31:0] eaddr, ewd;
      for (int n = 0; n < 1500; n++) begin
        if (n != 0) @(negedge clk);
        drive($urandom_range(0, 99) < 60, $urandom_range(0, 1), 4'($urandom), $urandom, $urandom,
              $urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 99) < 80,
              4'($urandom), $urandom, $urandom, $urandom);
        hold = locked && m1_req && m1_lock && cnt < LOCK_MAX;
        if (m0_req && m1_req) win = (hold || last == 0) ? 1 : 0;
        else if (m0_req)      win = 0;
        else if (m1_req)      win = 1;
        else                  win = -1;
        esel  = (win == 0) ? m0_sel   : (win == 1) ? m1_sel   : 4'h0;
        eaddr = (win == 0) ? m0_addr  : (win == 1) ? m1_addr  : 32'h0;
        ewd   = (win == 0) ? m0_wdata : (win == 1) ? m1_wdata : 32'h0;
        tag = $sformatf("rnd%0d", n);
        #1 cmp_outs(tag, win == 0, win == 1,
                    (m0_req && win != 0) || (win == 0 && !m0_we),
                    (win == 0) ? m0_we : (win == 1) ? m1_we : 1'b0,
                    esel, eaddr, ewd, pend0, pend1,
                    pend0 ? ram_rdata : 32'h0, pend1 ? ram_rdata : 32'h0);
        pend0 = (win == 0) && !m0_we;
        pend1 = (win == 1) && !m1_we;
        if (win >= 0) last = win;
        if (locked) begin
          if (hold) cnt = (cnt + 1 > LOCK_MAX) ? LOCK_MAX : cnt + 1;
          else begin locked = 0; cnt = 0; end
        end else if (win == 1 && m1_lock) begin
          locked = 1; cnt = 1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
